inst_rom_loader: RTL
====================

# inst_rom_loader

Instruction-memory responder for the CPU fetch port: it answers the core's `rom_ce_o`/`rom_addr_o` requests with `inst` data on the same cycle. It owns a word-addressed instruction RAM that is filled at boot from a byte-stream load port. The CPU core is held in reset until the image is complete. It sits beside the core at SoC top level, replacing a preinitialised ROM.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, log2 of instruction words stored (1024 words).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `ce_i`  in  1  fetch enable from the core's `rom_ce_o`.
- `addr_i`  in  32  byte fetch address from the core's `rom_addr_o`.
- `inst_o`  out  32  instruction to the core's `rom_data_i`.
- `ld_valid_i`  in  1  load byte valid.
- `ld_data_i`  in  8  load byte.
- `ld_last_i`  in  1  qualifies the final byte of the image.
- `ld_ready_o`  out  1  loader accepts a byte.
- `cpu_rst_o`  out  1  active-high reset to the CPU core.
- `load_done_o`  out  1  image loaded, core released.
- `err_o`  out  1  sticky error flag.

## Operation
- States: LOAD (reset state), RUN, ERR. There is no exit from RUN or ERR except `rst`.
- Reset values: state LOAD; byte count 0; write word address 0; word buffer 0; `cpu_rst_o` 1; `load_done_o` 0; `err_o` 0; `ld_ready_o` 1.
- RAM contents are not reset. Words beyond the loaded image read stale data.
- **LOAD**
  - `ld_ready_o` = 1.
  - Each cycle with `ld_valid_i`&`ld_ready_o` accepts one byte, packed big-endian: byte 0 goes to [31:24], byte 3 goes to [7:0].
  - On the 4th byte, the assembled word is written to RAM[waddr], waddr increments, and the byte count wraps to 0.
  - `ld_last_i` on an accepted byte:
    - The word is written with the unfilled low bytes zero-padded.
    - The next state is RUN.
  - A word completing at waddr = 2^DEPTH_LOG2−1 without `ld_last_i` is still written. The next state is ERR.
- **RUN**
  - `ld_ready_o` = 0 and load inputs are ignored.
  - `cpu_rst_o` = 0, `load_done_o` = 1.
- **ERR**
  - `ld_ready_o` = 0, `cpu_rst_o` = 1, `err_o` = 1.
- **Fetch** (combinational):
  - `inst_o` = 0 when `ce_i` = 0, or the state is not RUN.
  - Otherwise `inst_o` = RAM[addr_i[DEPTH_LOG2+1:2]].
- **Bad fetch** in RUN with `ce_i` = 1:
  - Applies when `addr_i[1:0]` ≠ 0, or any `addr_i[31:DEPTH_LOG2+2]` ≠ 0.
  - `inst_o` = 0 (NOP) and `err_o` sets on the next edge and stays set.
  - The state remains RUN and the core is not reset.
- **Reset mid-load:** the state returns to LOAD, the partial word is discarded and waddr returns to 0.

## Timing
- Fetch latency is 0 cycles. `inst_o` is valid in the cycle `addr_i` is presented, so the core's IF/ID register samples it on the next edge.
- Load write: the RAM is written on the edge that accepts the 4th byte (or the last byte). The word is readable once the state is RUN.
- `cpu_rst_o` and `load_done_o` are dedicated flops. They change on the same edge the state enters RUN, so there is no decode glitch on `cpu_rst_o`.
- The first fetch after release sees the core's reset PC. The whole image is already in RAM by then.
- `ld_ready_o` is a decode of the state flop and drops on the edge that accepts the last byte.
- Simultaneous `ld_last_i` on a 4th byte: one write, then RUN. There is no extra zero word.

## Structure
- Fetch-bus widths `InstBus`/`InstAddrBus`, plus `ZeroWord`, `ChipEnable` and `ChipDisable`, come from the shared defines header.
- Add loader state encodings (LOAD/RUN/ERR) to that header.
- One sub-module: `inst_ram`, with 2^DEPTH_LOG2×32, one synchronous write port and one asynchronous read port. The loader FSM, byte packer and error logic stay in `inst_rom_loader`.

## Test plan
- Reset, then stream 8 bytes 3C,01,12,34,34,21,00,05 with `ld_last_i` on the 8th byte:
  - RAM[0] = 3C011234 and RAM[1] = 34210005.
  - `cpu_rst_o` falls on the accept edge of byte 8.
  - A fetch at addr 0x4 with `ce_i` = 1 returns 34210005.
- Stream 6 bytes AA,BB,CC,DD,11,22 with last on byte 6:
  - RAM[1] = 11220000.
  - The state is RUN and `ld_ready_o` = 0 afterwards.
- During LOAD, drive `ce_i` = 1 at addr 0:
  - `inst_o` = 0 and `cpu_rst_o` = 1.
  - In RUN with `ce_i` = 0, `inst_o` = 0.
- With DEPTH_LOG2 = 2, stream 16 bytes with no last:
  - All 4 words are written.
  - The state becomes ERR, `err_o` = 1, `cpu_rst_o` stays 1 and `ld_ready_o` = 0.
- In RUN, fetch addr 0x2, then addr 0x00001000 (DEPTH_LOG2 = 10):
  - Both return 0.
  - `err_o` sets on the next edge and stays 1. `load_done_o` stays 1.
- Assert `rst` low after 5 accepted bytes:
  - Outputs are asynchronously restored to their reset values.
  - A reload of 4 bytes with last writes RAM[0], not RAM[1].

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// inst_rom_loader_pkg : shared fetch-bus defines and loader state encodings
// Rev 1.0
// ============================================================================
package inst_rom_loader_pkg;

    localparam int          c_inst_bus      = 32;
    localparam int          c_inst_addr_bus = 32;
    localparam logic [31:0] c_zero_word     = 32'h0000_0000;
    localparam logic        c_chip_enable   = 1'b1;
    localparam logic        c_chip_disable  = 1'b0;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } loader_state_e;

endpackage : inst_rom_loader_pkg
`default_nettype wire

// File: rtl/inst_ram.sv
`default_nettype none
// ============================================================================
// inst_ram : instruction word RAM, synchronous write, asynchronous read
// Rev 1.0
// ============================================================================
module inst_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule : inst_ram
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// inst_rom_loader : boot-loaded instruction memory answering the core's fetch
// Rev 1.0
// ============================================================================
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce_i,
    input  logic [c_inst_addr_bus-1:0] addr_i,
    output logic [c_inst_bus-1:0]      inst_o,
    input  logic                       ld_valid_i,
    input  logic [7:0]                 ld_data_i,
    input  logic                       ld_last_i,
    output logic                       ld_ready_o,
    output logic                       cpu_rst_o,
    output logic                       load_done_o,
    output logic                       err_o
);

    loader_state_e           r_state;
    logic [1:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_waddr;
    logic [c_inst_bus-1:0]   r_buf;
    logic                    r_cpu_rst;
    logic                    r_load_done;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_we;
    logic                    w_last_slot;
    logic                    w_bad_addr;
    logic [c_inst_bus-1:0]   w_word;
    logic [c_inst_bus-1:0]   w_rdata;

    assign w_accept    = ld_valid_i && (r_state == ST_LOAD);
    assign w_we        = w_accept && ((r_cnt == 2'd3) || ld_last_i);
    assign w_last_slot = (r_waddr == {DEPTH_LOG2{1'b1}});
    assign w_bad_addr  = (addr_i[1:0] != 2'b00) ||
                         (addr_i[c_inst_addr_bus-1:DEPTH_LOG2+2] != '0);

    // Buffer is cleared after each write, so unfilled low bytes read as zero.
    always_comb begin
        w_word = r_buf;
        case (r_cnt)
            2'd0:    w_word[31:24] = ld_data_i;
            2'd1:    w_word[23:16] = ld_data_i;
            2'd2:    w_word[15:8]  = ld_data_i;
            default: w_word[7:0]   = ld_data_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_LOAD;
            r_cnt       <= 2'd0;
            r_waddr     <= '0;
            r_buf       <= c_zero_word;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_we) begin
                        r_buf   <= c_zero_word;
                        r_cnt   <= 2'd0;
                        r_waddr <= r_waddr + 1'b1;
                        if (ld_last_i) begin
                            r_state     <= ST_RUN;
                            r_cpu_rst   <= 1'b0;
                            r_load_done <= 1'b1;
                        end else if (w_last_slot) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_buf <= w_word;
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_RUN: begin
                    if ((ce_i == c_chip_enable) && w_bad_addr) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_ERR;
                    r_cpu_rst <= 1'b1;
                    r_err     <= 1'b1;
                end
            endcase
        end
    end

    inst_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (c_inst_bus)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (w_word),
        .i_raddr (addr_i[DEPTH_LOG2+1:2]),
        .o_rdata (w_rdata)
    );

    assign inst_o = ((ce_i == c_chip_disable) || (r_state != ST_RUN) || w_bad_addr)
                  ? c_zero_word : w_rdata;

    assign ld_ready_o  = (r_state == ST_LOAD);
    assign cpu_rst_o   = r_cpu_rst;
    assign load_done_o = r_load_done;
    assign err_o       = r_err;

endmodule : inst_rom_loader
`default_nettype wire
